multi_breathing_led: RTL
========================

Name: multi_breathing_led

Overview:
- Multi-channel successor to the single-LED breathing design: one shared prescaler and one shared PWM counter drive CHANNELS independent LED outputs.
- Each channel is set through a simple write port to one of four modes: off, solid, breathe or blink, each with its own peak brightness.
- Sits between the board LED pins and whatever logic (UART command decoder, button handler) selects the LED patterns.

Parameters:
- CHANNELS, 3, number of LED channels (1..16).
- BITS, 5, PWM/brightness resolution; level range 0..2^BITS-1.
- PRESCALE_BITS, 18, width of the step prescaler; one brightness step every 2^PRESCALE_BITS clk cycles.
- Derived localparam CH_W = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- wrEn  in  1  write strobe, one-cycle, sampled on rising clk.
- wrChannel  in  CH_W  target channel of the write.
- wrMode  in  2  0=off, 1=solid, 2=breathe, 3=blink.
- wrLevel  in  BITS  peak brightness (maxLevel) for the channel.
- led  out  CHANNELS  PWM outputs, active-high.
- tick  out  1  prescaler step pulse, exposed for debug and benches.

Behaviour:
- Reset: all registers are cleared asynchronously while resetN=0.
  - Every channel goes to mode=off, maxLevel=0, level=0, dir=up, blinkCnt=0, blinkOn=0.
  - pwmCnt=0, prescaler=0, led=0, tick=0.
  - Deassertion takes effect on the next clk edge.
- Prescaler: a PRESCALE_BITS-wide free-running counter.
  - tick=1 for exactly one cycle when the counter equals all-ones, so the first tick comes 2^PRESCALE_BITS-1 cycles after reset release, then one every 2^PRESCALE_BITS cycles.
- PWM: pwmCnt is a BITS-wide free-running counter that wraps at 2^BITS.
  - led[i] is registered: led[i] <= (pwmCnt < duty[i]). Latency is one cycle.
  - duty=0 gives a constant 0. duty=2^BITS-1 gives high for 2^BITS-1 of every 2^BITS cycles (100% is not reachable).
- Write: when wrEn=1 and wrChannel<CHANNELS, the channel takes mode=wrMode and maxLevel=wrLevel, and is restarted: level=0, dir=up, blinkCnt=0, blinkOn=0.
  - A write with wrChannel>=CHANNELS is ignored.
  - A write in the same cycle as tick overrides that tick for the written channel only.
- Per-channel duty, before the optional mapping:
  - off: 0.
  - solid: maxLevel.
  - breathe: level.
  - blink: maxLevel when blinkOn=1, else 0.
- Breathe state machine (dir is UP or DOWN), advanced on tick only:
  - UP: if level>=maxLevel, go to DOWN and set level = level>0 ? level-1 : 0. Otherwise level+1.
  - DOWN: if level==0, go to UP and set level = maxLevel>0 ? 1 : 0. Otherwise level-1.
  - With maxLevel=0 the level stays 0.
  - Lowering maxLevel below level with dir=UP is covered by the restart-on-write rule.
  - The peak value and the zero value are each held for one tick.
- Blink: on each tick blinkCnt increments modulo 2^BITS. On the wrap from all-ones to 0, blinkOn toggles, so each phase lasts 2^BITS ticks.
- In off and solid modes the level, dir and blink registers do not advance.

Optional Feature:
- Macro GAMMA_EN.
- When defined, duty is replaced by gammaDuty = (duty*duty) >> BITS, computed at full 2*BITS width before the shift. For BITS=5: 31 becomes 30, 16 becomes 8, 5 becomes 0.
- When undefined, duty drives the PWM comparator directly (linear).
- The mapping is purely combinational before the led register, so latency is unchanged.

Test Plan:
- Reset check, PRESCALE_BITS=2, BITS=5: hold resetN=0 for 5 cycles -> led=0, tick=0. After release, first tick at cycle 3, then every 4 cycles.
- Solid: write ch0 mode=1 level=8 -> led[0] high for 8 of every 32 cycles, starting the cycle after pwmCnt=0 is registered. Other channels stay 0.
- Breathe, ch1 mode=2 level=3: observed levels per tick are 1,2,3,2,1,0,1,2,3… Check duty via high-cycle count per 32-cycle PWM period.
- Blink, ch2 mode=3 level=31 -> led[2] at 31/32 duty for 32 ticks, then 0 for 32 ticks, repeating.
- Boundaries:
  - Write wrChannel=3 with CHANNELS=3 -> no state change on any channel.
  - Write coincident with tick -> written channel restarts at level=0; other channels step normally.
  - resetN pulsed low mid-breathe -> led=0 immediately, without waiting for a clk edge.
- With GAMMA_EN, solid level=16 -> 8/32 duty; level=31 -> 30/32 duty.

Source files
------------

// File: rtl/multi_breathing_led.sv
// Multi-channel LED driver with one shared prescaler and one shared PWM counter.
// Each channel runs off, solid, breathe or blink at its own peak brightness.
// Build option: define GAMMA_EN to square-map duty before the PWM comparator.
// Ports:
//   clk       - system clock
//   resetN    - asynchronous active-low reset
//   wrEn      - one-cycle write strobe
//   wrChannel - channel to write (writes to channels >= CHANNELS are ignored)
//   wrMode    - 0=off 1=solid 2=breathe 3=blink
//   wrLevel   - peak brightness of the channel
//   led       - registered PWM outputs, active-high
//   tick      - one-cycle brightness step pulse
module multi_breathing_led #(
    parameter int CHANNELS      = 3,
    parameter int BITS          = 5,
    parameter int PRESCALE_BITS = 18,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                wrEn,
    input  logic [CH_W-1:0]     wrChannel,
    input  logic [1:0]          wrMode,
    input  logic [BITS-1:0]     wrLevel,
    output logic [CHANNELS-1:0] led,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [BITS-1:0] ONE = BITS'(1);

    logic [PRESCALE_BITS-1:0] presc_q;
    logic [BITS-1:0]          pwm_q;

    mode_t           mode_q   [CHANNELS];
    mode_t           mode_d   [CHANNELS];
    logic [BITS-1:0] max_q    [CHANNELS];
    logic [BITS-1:0] max_d    [CHANNELS];
    logic [BITS-1:0] level_q  [CHANNELS];
    logic [BITS-1:0] level_d  [CHANNELS];
    dir_t            dir_q    [CHANNELS];
    dir_t            dir_d    [CHANNELS];
    logic [BITS-1:0] bcnt_q   [CHANNELS];
    logic [BITS-1:0] bcnt_d   [CHANNELS];
    logic            blink_q  [CHANNELS];
    logic            blink_d  [CHANNELS];
    logic [BITS-1:0] duty     [CHANNELS];
    logic [BITS-1:0] duty_pwm [CHANNELS];
`ifdef GAMMA_EN
    logic [2*BITS-1:0] sq     [CHANNELS];
`endif

    // Tick fires in the cycle the prescaler sits at all-ones.
    assign tick = &presc_q;

    // Per-channel next state. A write wins over a coincident tick.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]  = mode_q[i];
            max_d[i]   = max_q[i];
            level_d[i] = level_q[i];
            dir_d[i]   = dir_q[i];
            bcnt_d[i]  = bcnt_q[i];
            blink_d[i] = blink_q[i];
            if (wrEn && (wrChannel == CH_W'(i))) begin
                mode_d[i]  = mode_t'(wrMode);
                max_d[i]   = wrLevel;
                level_d[i] = '0;
                dir_d[i]   = DIR_UP;
                bcnt_d[i]  = '0;
                blink_d[i] = 1'b0;
            end else if (tick) begin
                case (mode_q[i])
                    MODE_BREATHE: begin
                        if (dir_q[i] == DIR_UP) begin
                            if (level_q[i] >= max_q[i]) begin
                                dir_d[i]   = DIR_DOWN;
                                level_d[i] = (level_q[i] != '0) ?
                                             level_q[i] - ONE : '0;
                            end else begin
                                level_d[i] = level_q[i] + ONE;
                            end
                        end else begin
                            if (level_q[i] == '0) begin
                                dir_d[i]   = DIR_UP;
                                level_d[i] = (max_q[i] != '0) ? ONE : '0;
                            end else begin
                                level_d[i] = level_q[i] - ONE;
                            end
                        end
                    end
                    MODE_BLINK: begin
                        bcnt_d[i] = bcnt_q[i] + ONE;
                        if (&bcnt_q[i]) begin
                            blink_d[i] = ~blink_q[i];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Duty selection and optional square-law mapping.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            duty[i] = '0;
            case (mode_q[i])
                MODE_SOLID:   duty[i] = max_q[i];
                MODE_BREATHE: duty[i] = level_q[i];
                MODE_BLINK:   duty[i] = blink_q[i] ? max_q[i] : '0;
                default:      duty[i] = '0;
            endcase
`ifdef GAMMA_EN
            sq[i] = {{BITS{1'b0}}, duty[i]} * {{BITS{1'b0}}, duty[i]};
            duty_pwm[i] = sq[i][2*BITS-1:BITS];
`else
            duty_pwm[i] = duty[i];
`endif
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            presc_q <= '0;
            pwm_q   <= '0;
            led     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]  <= MODE_OFF;
                max_q[i]   <= '0;
                level_q[i] <= '0;
                dir_q[i]   <= DIR_UP;
                bcnt_q[i]  <= '0;
                blink_q[i] <= 1'b0;
            end
        end else begin
            presc_q <= presc_q + 1'b1;
            pwm_q   <= pwm_q + ONE;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]  <= mode_d[i];
                max_q[i]   <= max_d[i];
                level_q[i] <= level_d[i];
                dir_q[i]   <= dir_d[i];
                bcnt_q[i]  <= bcnt_d[i];
                blink_q[i] <= blink_d[i];
                led[i]     <= (pwm_q < duty_pwm[i]);
            end
        end
    end

endmodule
